// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        CFG,
        IDLE,
        SEND,
        BRK_WAIT
    } state_e;

    localparam logic [9:0] TXW_BRK_ON  = 10'h201;
    localparam logic [9:0] TXW_BRK_OFF = 10'h200;

    localparam int BITS_LSB = 13;
    localparam int DIV_W    = 13;
    localparam int CFG_W    = BITS_LSB + 4;

    function automatic logic [CFG_W-1:0] pack_cfg(input int bits, input int div);
        return {bits[3:0], div[DIV_W-1:0]};
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin pick: first requester after the pointer, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         upd_i,
    output logic [N-1:0] gnt_o,
    output logic         any_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] cand;
    logic [IW-1:0] pick;

    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        cand  = '0;
        pick  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr_q) + k) % N);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                pick        = cand;
            end
        end
    end

    // Reset to the last index so the first search starts at requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IW'(N - 1);
        end else if (upd_i && any_o) begin
            ptr_q <= pick;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART TX port between requesters, sequences BREAK and config
// writes, and splits received words into bytes and BREAK status.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int CFG_BITS   = 10,
    parameter int CFG_DIV    = 1,
    parameter int HOLDOFF    = 2,
    parameter int BRK_CYCLES = 2000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    input  logic [N_REQ-1:0]   req_brk,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    input  logic               cfg_wr_stb,
    input  logic [CFG_W-1:0]   cfg_wr_data,
    output logic               uart_reg_cs,
    output logic [31:0]        uart_reg_data,
    input  logic               uart_empty,
    output logic               uart_in_stb,
    output logic [9:0]         uart_in_data,
    input  logic               uart_out_stb,
    input  logic [11:0]        uart_out_data,
    output logic               rx_stb,
    output logic [7:0]         rx_data,
    output logic               rx_break
);

    localparam int HW = $clog2(HOLDOFF + 2);
    localparam int BW = $clog2(BRK_CYCLES + 2);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [BW-1:0]      brk_q, brk_d;
    logic               pend_q, pend_d;
    logic [CFG_W-1:0]   cfg_q, cfg_d;
    logic               cs_q, cs_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rx_stb_q, rx_stb_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_brk_q, rx_brk_d;

    logic               tx_ok;
    logic               stb;
    logic [9:0]         word;
    logic               ack;
    logic               arb_upd;
    logic [N_REQ-1:0]   arb_gnt;
    logic               arb_any;
    logic               o_valid;
    logic               o_last;
    logic               o_brk;
    logic [7:0]         o_data;
    logic               rx_unused;

    assign tx_ok = uart_empty && (hold_q == '0);

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req_valid),
        .upd_i (arb_upd),
        .gnt_o (arb_gnt),
        .any_o (arb_any)
    );

    always_comb begin
        o_valid = 1'b0;
        o_last  = 1'b0;
        o_brk   = 1'b0;
        o_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                o_valid = req_valid[i];
                o_last  = req_last[i];
                o_brk   = req_brk[i];
                o_data  = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        brk_d   = brk_q;
        pend_d  = pend_q;
        cfg_d   = cfg_q;
        cs_d    = 1'b0;
        rdata_d = '0;
        stb     = 1'b0;
        word    = '0;
        ack     = 1'b0;
        arb_upd = 1'b0;
        if (cfg_wr_stb) begin
            cfg_d  = cfg_wr_data;
            pend_d = 1'b1;
        end
        unique case (state_q)
            CFG: begin
                cs_d    = 1'b1;
                rdata_d = 32'(cfg_q);
                if (!cfg_wr_stb) pend_d = 1'b0;
                state_d = IDLE;
            end
            IDLE: begin
                if (pend_q && tx_ok) begin
                    state_d = CFG;
                end else if (arb_any) begin
                    arb_upd = 1'b1;
                    grant_d = arb_gnt;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_ok && o_valid) begin
                    stb = 1'b1;
                    if (o_brk) begin
                        word    = TXW_BRK_ON;
                        brk_d   = BW'(BRK_CYCLES);
                        state_d = BRK_WAIT;
                    end else begin
                        word = {2'b00, o_data};
                        ack  = 1'b1;
                        if (o_last) begin
                            grant_d = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            BRK_WAIT: begin
                if (brk_q != '0) begin
                    brk_d = brk_q - 1'b1;
                end else if (tx_ok) begin
                    stb  = 1'b1;
                    word = TXW_BRK_OFF;
                    ack  = 1'b1;
                    if (o_last) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = CFG;
        endcase
    end

    // uart_empty lags the strobe, so it is ignored for a few cycles.
    always_comb begin
        hold_d = hold_q;
        if (stb) begin
            hold_d = HW'(HOLDOFF);
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    always_comb begin
        rx_stb_d  = uart_out_stb && !uart_out_data[11];
        rx_data_d = rx_stb_d ? uart_out_data[7:0] : rx_data_q;
        rx_brk_d  = (uart_out_stb && uart_out_data[11]) ? uart_out_data[0] : rx_brk_q;
    end

    assign rx_unused = ^uart_out_data[10:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CFG;
            grant_q   <= '0;
            hold_q    <= '0;
            brk_q     <= '0;
            pend_q    <= 1'b0;
            cfg_q     <= pack_cfg(CFG_BITS, CFG_DIV);
            cs_q      <= 1'b0;
            rdata_q   <= '0;
            rx_stb_q  <= 1'b0;
            rx_data_q <= '0;
            rx_brk_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            brk_q     <= brk_d;
            pend_q    <= pend_d;
            cfg_q     <= cfg_d;
            cs_q      <= cs_d;
            rdata_q   <= rdata_d;
            rx_stb_q  <= rx_stb_d;
            rx_data_q <= rx_data_d;
            rx_brk_q  <= rx_brk_d;
        end
    end

    assign req_ready     = ack ? grant_q : '0;
    assign grant         = grant_q;
    assign uart_reg_cs   = cs_q;
    assign uart_reg_data = rdata_q;
    assign uart_in_stb   = stb;
    assign uart_in_data  = word;
    assign rx_stb        = rx_stb_q;
    assign rx_data       = rx_data_q;
    assign rx_break      = rx_brk_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a small UART model and RX loopback.
module tb_uart_tx_sched;

    localparam int HOLDOFF = 2;
    localparam int BRK     = 2000;

    typedef struct packed {
        logic       brk;
        logic       last;
        logic [7:0] data;
    } rw_t;

    typedef struct packed {
        logic        is_cfg;
        logic [31:0] data;
        logic [1:0]  rdy;
        logic [1:0]  gnt;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_brk;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        cfg_wr_stb;
    logic [16:0] cfg_wr_data;
    logic        uart_reg_cs;
    logic [31:0] uart_reg_data;
    logic        uart_empty;
    logic        uart_in_stb;
    logic [9:0]  uart_in_data;
    logic        uart_out_stb;
    logic [11:0] uart_out_data;
    logic        rx_stb;
    logic [7:0]  rx_data;
    logic        rx_break;

    rw_t        rq0[$];
    rw_t        rq1[$];
    ev_t        evq[$];
    logic [7:0] rxq[$];
    logic       brkq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_stb = -1000000;

    logic [1:0] acc_n = 2'b00;
    logic       stb_n = 1'b0;
    logic [9:0] word_n = '0;
    logic       prev_brk = 1'b0;
    ev_t        mon_e;
    logic [7:0] mon_b;
    logic       mon_k;

    int         pend_cnt = 0;
    int         busy = 0;
    logic [9:0] lb_w = '0;
    bit         lb_p = 1'b0;

    uart_tx_sched #(
        .N_REQ      (2),
        .CFG_BITS   (10),
        .CFG_DIV    (1),
        .HOLDOFF    (HOLDOFF),
        .BRK_CYCLES (BRK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_brk       (req_brk),
        .req_ready     (req_ready),
        .grant         (grant),
        .cfg_wr_stb    (cfg_wr_stb),
        .cfg_wr_data   (cfg_wr_data),
        .uart_reg_cs   (uart_reg_cs),
        .uart_reg_data (uart_reg_data),
        .uart_empty    (uart_empty),
        .uart_in_stb   (uart_in_stb),
        .uart_in_data  (uart_in_data),
        .uart_out_stb  (uart_out_stb),
        .uart_out_data (uart_out_data),
        .rx_stb        (rx_stb),
        .rx_data       (rx_data),
        .rx_break      (rx_break)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h, expected no event", name, act);
    endtask

    task automatic push_req(input int r, input bit brk, input bit last, input logic [7:0] d);
        rw_t w;
        w = '{brk: brk, last: last, data: d};
        if (r == 0) rq0.push_back(w);
        else rq1.push_back(w);
    endtask

    task automatic exp_tx(input logic [9:0] w, input logic [1:0] rdy, input logic [1:0] g);
        evq.push_back('{is_cfg: 1'b0, data: 32'(w), rdy: rdy, gnt: g});
        if (w[9]) brkq.push_back(w[0]);
        else rxq.push_back(w[7:0]);
    endtask

    task automatic exp_cfg(input logic [31:0] d);
        evq.push_back('{is_cfg: 1'b1, data: d, rdy: 2'b00, gnt: 2'b00});
    endtask

    task automatic tx_byte(input int r, input logic [7:0] d, input bit last);
        push_req(r, 1'b0, last, d);
        exp_tx({2'b00, d}, 2'(1 << r), 2'(1 << r));
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((evq.size() + rxq.size() + brkq.size() + rq0.size() + rq1.size()) != 0
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, evq.size() + rxq.size() + brkq.size() + rq0.size() + rq1.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {grant, req_ready, uart_reg_cs, uart_in_stb, uart_in_data,
                     rx_stb, rx_data, rx_break}, 0);
        check({name, " regdata"}, uart_reg_data, 0);
    endtask

    // Monitor: samples mid-cycle, so values are those seen by the next edge.
    always @(negedge clk) begin
        cyc++;
        acc_n  = req_ready;
        stb_n  = uart_in_stb;
        word_n = uart_in_data;
        if (!rst_n) begin
            prev_brk = rx_break;
        end else begin
            if (uart_reg_cs) begin
                check("cfg while granted", grant, 0);
                check("cfg while busy", uart_empty, 1);
                if (evq.size() == 0) begin
                    fail_now("cfg unexpected", uart_reg_data);
                end else begin
                    mon_e = evq.pop_front();
                    check("cfg kind", mon_e.is_cfg, 1);
                    check("cfg data", uart_reg_data, mon_e.data);
                end
            end
            if (uart_in_stb) begin
                check("tx gap", 32'((cyc - last_stb) >= HOLDOFF + 1), 1);
                check("tx while busy", uart_empty, 1);
                if (evq.size() == 0) begin
                    fail_now("tx unexpected", uart_in_data);
                end else begin
                    mon_e = evq.pop_front();
                    check("tx kind", mon_e.is_cfg, 0);
                    check("tx word", uart_in_data, mon_e.data);
                    check("tx ready", req_ready, mon_e.rdy);
                    check("tx grant", grant, mon_e.gnt);
                    if (mon_e.data == 32'h200)
                        check("brk hold", 32'((cyc - last_stb) >= BRK), 1);
                end
                last_stb = cyc;
            end else if (req_ready != 2'b00) begin
                fail_now("ready without strobe", req_ready);
            end
            if (rx_stb) begin
                if (rxq.size() == 0) begin
                    fail_now("rx unexpected", rx_data);
                end else begin
                    mon_b = rxq.pop_front();
                    check("rx data", rx_data, mon_b);
                end
            end
            if (rx_break !== prev_brk) begin
                if (brkq.size() == 0) begin
                    fail_now("rx_break unexpected", rx_break);
                end else begin
                    mon_k = brkq.pop_front();
                    check("rx_break", rx_break, mon_k);
                end
            end
            prev_brk = rx_break;
        end
    end

    // Requesters and UART model update just after each active edge.
    always @(posedge clk) begin
        #1;
        if (acc_n[0] && rq0.size() > 0) void'(rq0.pop_front());
        if (acc_n[1] && rq1.size() > 0) void'(rq1.pop_front());
        req_valid = {rq1.size() > 0, rq0.size() > 0};
        req_data  = {(rq1.size() > 0) ? rq1[0].data : 8'h00,
                     (rq0.size() > 0) ? rq0[0].data : 8'h00};
        req_last  = {(rq1.size() > 0) ? rq1[0].last : 1'b0,
                     (rq0.size() > 0) ? rq0[0].last : 1'b0};
        req_brk   = {(rq1.size() > 0) ? rq1[0].brk : 1'b0,
                     (rq0.size() > 0) ? rq0[0].brk : 1'b0};
        uart_out_stb = 1'b0;
        if (stb_n) begin
            pend_cnt = 1;
            lb_w     = word_n;
            lb_p     = 1'b1;
        end else if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                uart_empty = 1'b0;
                busy       = 4;
            end
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                uart_empty = 1'b1;
                if (lb_p) begin
                    uart_out_stb  = 1'b1;
                    uart_out_data = lb_w[9] ? {1'b1, 10'b0, lb_w[0]} : {4'b0, lb_w[7:0]};
                    lb_p          = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        rst_n         = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        req_last      = '0;
        req_brk       = '0;
        cfg_wr_stb    = 1'b0;
        cfg_wr_data   = '0;
        uart_empty    = 1'b1;
        uart_out_stb  = 1'b0;
        uart_out_data = '0;

        // 1: reset state, then a single config write with the defaults
        repeat (3) @(negedge clk);
        check_reset_outputs("reset outputs");
        exp_cfg(32'h0001_4001);
        rst_n = 1'b1;
        drain("t1 cfg after reset", 50);

        // 2: req0 packet locked while req1 waits
        tx_byte(0, 8'h11, 1'b0);
        tx_byte(0, 8'h22, 1'b0);
        tx_byte(0, 8'h33, 1'b1);
        tx_byte(1, 8'h44, 1'b1);
        drain("t2 packet lock", 200);

        // 3: single-byte packets alternate
        push_req(0, 1'b0, 1'b1, 8'h55);
        push_req(0, 1'b0, 1'b1, 8'h66);
        push_req(1, 1'b0, 1'b1, 8'h77);
        push_req(1, 1'b0, 1'b1, 8'h88);
        exp_tx(10'h055, 2'b01, 2'b01);
        exp_tx(10'h077, 2'b10, 2'b10);
        exp_tx(10'h066, 2'b01, 2'b01);
        exp_tx(10'h088, 2'b10, 2'b10);
        drain("t3 alternation", 200);

        // 4: BREAK on/off from req1 with loopback
        push_req(1, 1'b1, 1'b1, 8'hA5);
        exp_tx(10'h201, 2'b00, 2'b10);
        exp_tx(10'h200, 2'b10, 2'b10);
        drain("t4 break", 3000);

        // 5: runtime config during a packet waits for the packet end
        for (int i = 0; i < 5; i++) tx_byte(0, 8'hA1 + 8'(i), i == 4);
        exp_cfg(32'h0001_2003);
        n = 0;
        while (rq0.size() > 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5 two bytes sent", rq0.size(), 3);
        cfg_wr_data = {4'd9, 13'd3};
        cfg_wr_stb  = 1'b1;
        @(negedge clk);
        cfg_wr_stb  = 1'b0;
        drain("t5 cfg deferred", 300);
        tx_byte(1, 8'hB1, 1'b1);
        drain("t5 next grant", 100);

        // 6: reset during BREAK hold
        push_req(0, 1'b1, 1'b1, 8'h00);
        exp_tx(10'h201, 2'b00, 2'b01);
        n = 0;
        while ((evq.size() != 0 || rx_break !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6 break looped back", rx_break, 1);
        repeat (50) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6 async reset");
        rq0.delete();
        rq1.delete();
        exp_cfg(32'h0001_4001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tx_byte(0, 8'hC1, 1'b1);
        tx_byte(1, 8'hC2, 1'b1);
        drain("t6 restart", 200);

        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
